// File: rtl/bcd_pkg.sv
// Shared types, 7-segment patterns and the BCD-to-segment decoder used by the
// BCD up/down counter and its bench.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   // Active-low {dp,g,f,e,d,c,b,a}; dp is always off (1).
   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Non-decimal codes never reach a digit register; blank them defensively.
   function automatic logic [7:0] bcd_to_seg(input bcd_digit_t d);
      if (d > 4'd9) return SEG_BLANK;
      return SEG_DIGIT[d];
   endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Board-side signal bundle of the BCD up/down counter. The counter side uses
// the slave modport; whatever drives the buttons and load uses master.
// DB_UP_N/DB_DN_N expose the debounced button state for observation.
interface bcd_updown_counter_if #(
   parameter int P_DIGITS = 2
);
   logic                    BTN_UP_N;
   logic                    BTN_DN_N;
   logic                    LOAD;
   logic [4*P_DIGITS-1:0]   LOAD_VAL;
   logic [4*P_DIGITS-1:0]   BCD;
   logic [8*P_DIGITS-1:0]   HEX;
   logic                    CARRY;
   logic                    BORROW;
   logic                    LOAD_ERR;
   logic                    DB_UP_N;
   logic                    DB_DN_N;

   modport master (
      output BTN_UP_N, BTN_DN_N, LOAD, LOAD_VAL,
      input  BCD, HEX, CARRY, BORROW, LOAD_ERR, DB_UP_N, DB_DN_N
   );

   modport slave (
      input  BTN_UP_N, BTN_DN_N, LOAD, LOAD_VAL,
      output BCD, HEX, CARRY, BORROW, LOAD_ERR, DB_UP_N, DB_DN_N
   );
endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: 2-FF synchroniser, then a run-length counter that only
// accepts a new level after P_DEBOUNCE_CNT consecutive differing samples.
// PRESS pulses for one cycle on the same edge the debounced level falls.
module btn_debounce #(
   parameter int P_DEBOUNCE_CNT = 2**15
) (
   input  logic CLK1,
   input  logic RST_N,
   input  logic BTN_N,
   output logic DB_N,
   output logic PRESS
);

   localparam int              CW       = (P_DEBOUNCE_CNT > 2) ? $clog2(P_DEBOUNCE_CNT) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(P_DEBOUNCE_CNT - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          db_q, db_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Next-state: count while the synced input disagrees with the accepted level.
   always_comb begin
      sync1_d = BTN_N;
      sync2_d = sync1_q;
      db_d    = db_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d    = ~db_q;
            press_d = db_q;   // only a 1->0 change is a press
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers; reset to the released level.
   always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         db_q    <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         db_q    <= db_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign DB_N  = db_q;
   assign PRESS = press_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with debounced buttons, parallel load and
// wrap/saturate selection, driving one registered 7-segment digit per BCD digit.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int P_DIGITS       = 2,
   parameter int P_DEBOUNCE_CNT = 2**15,
   parameter bit P_WRAP         = 1'b1
) (
   input  logic                  CLK1,
   input  logic                  RST_N,
   bcd_updown_counter_if.slave   bus
);

   localparam int BW = 4 * P_DIGITS;

   logic up_press, dn_press;
   logic up_db_n, dn_db_n;
   logic up_step, dn_step;

   btn_debounce #(.P_DEBOUNCE_CNT(P_DEBOUNCE_CNT)) u_db_up (
      .CLK1  (CLK1),
      .RST_N (RST_N),
      .BTN_N (bus.BTN_UP_N),
      .DB_N  (up_db_n),
      .PRESS (up_press)
   );

   btn_debounce #(.P_DEBOUNCE_CNT(P_DEBOUNCE_CNT)) u_db_dn (
      .CLK1  (CLK1),
      .RST_N (RST_N),
      .BTN_N (bus.BTN_DN_N),
      .DB_N  (dn_db_n),
      .PRESS (dn_press)
   );

   // LOAD beats any step; simultaneous up and down cancel each other.
   assign up_step = up_press & ~dn_press & ~bus.LOAD;
   assign dn_step = dn_press & ~up_press & ~bus.LOAD;

   logic [BW-1:0]         bcd_cur, bcd_d, stepped;
   logic [8*P_DIGITS-1:0] hex_cur;
   logic                  carry_q, carry_d;
   logic                  borrow_q, borrow_d;
   logic                  load_err_q, load_err_d;
   logic                  up_chain, dn_chain, load_bad;
   bcd_digit_t            cur, lv;

   // Next count: ripple carry/borrow through the digits, then apply load or wrap/saturate.
   always_comb begin
      stepped    = bcd_cur;
      bcd_d      = bcd_cur;
      up_chain   = up_step;
      dn_chain   = dn_step;
      load_bad   = 1'b0;
      carry_d    = 1'b0;
      borrow_d   = 1'b0;
      load_err_d = load_err_q;
      cur        = '0;
      lv         = '0;
      for (int i = 0; i < P_DIGITS; i++) begin
         cur = bcd_cur[4*i +: 4];
         if (up_chain)
            stepped[4*i +: 4] = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
         else if (dn_chain)
            stepped[4*i +: 4] = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
         up_chain = up_chain & (cur == 4'd9);
         dn_chain = dn_chain & (cur == 4'd0);
      end
      // After the loop the chains are set only when every digit was 9 (or 0).
      if (bus.LOAD) begin
         for (int i = 0; i < P_DIGITS; i++) begin
            lv = bus.LOAD_VAL[4*i +: 4];
            if (lv > 4'd9) begin
               bcd_d[4*i +: 4] = 4'd0;
               load_bad        = 1'b1;
            end else begin
               bcd_d[4*i +: 4] = lv;
            end
         end
         load_err_d = load_bad;
      end else if (up_step || dn_step) begin
         carry_d  = up_chain;
         borrow_d = dn_chain;
         if (!P_WRAP && (up_chain || dn_chain))
            bcd_d = bcd_cur;
         else
            bcd_d = stepped;
      end
   end

   for (genvar g = 0; g < P_DIGITS; g++) begin : g_digit
      bcd_digit_t  digit_q, digit_d;
      logic [7:0]  hex_q, hex_d;

      assign digit_d = bcd_d[4*g +: 4];
      assign hex_d   = bcd_to_seg(digit_d);

      // Per-digit count and segment registers; HEX tracks BCD on the same edge.
      always_ff @(posedge CLK1 or negedge RST_N) begin
         if (!RST_N) begin
            digit_q <= '0;
            hex_q   <= SEG_DIGIT[0];
         end else begin
            digit_q <= digit_d;
            hex_q   <= hex_d;
         end
      end

      assign bcd_cur[4*g +: 4] = digit_q;
      assign hex_cur[8*g +: 8] = hex_q;
   end

   // Boundary pulses and sticky load-error flag.
   always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) begin
         carry_q    <= 1'b0;
         borrow_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         carry_q    <= carry_d;
         borrow_q   <= borrow_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.BCD      = bcd_cur;
   assign bus.HEX      = hex_cur;
   assign bus.CARRY    = carry_q;
   assign bus.BORROW   = borrow_q;
   assign bus.LOAD_ERR = load_err_q;
   assign bus.DB_UP_N  = up_db_n;
   assign bus.DB_DN_N  = dn_db_n;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a wrapping and a saturating instance receive
// identical stimulus; a decimal model pushes expected results when a press or
// load is driven and they are popped at the edge the counter must respond.
module tb_bcd_updown_counter;

   localparam int DIG = 2;
   localparam int DBC = 16;
   localparam int W   = 20;  // {bcd_w[8], carry_w, borrow_w, bcd_s[8], carry_s, borrow_s}

   logic CLK1 = 1'b0;
   logic RST_N;

   always #5 CLK1 = ~CLK1;

   bcd_updown_counter_if #(.P_DIGITS(DIG)) bus_w ();
   bcd_updown_counter_if #(.P_DIGITS(DIG)) bus_s ();

   bcd_updown_counter #(.P_DIGITS(DIG), .P_DEBOUNCE_CNT(DBC), .P_WRAP(1'b1)) dut_w (
      .CLK1  (CLK1),
      .RST_N (RST_N),
      .bus   (bus_w)
   );

   bcd_updown_counter #(.P_DIGITS(DIG), .P_DEBOUNCE_CNT(DBC), .P_WRAP(1'b0)) dut_s (
      .CLK1  (CLK1),
      .RST_N (RST_N),
      .bus   (bus_s)
   );

   // ---------------- scoreboard / model state ----------------
   logic [W-1:0] exp_q[$];
   int n_total = 0;
   int n_bad   = 0;
   int val_w   = 0;
   int val_s   = 0;
   bit err     = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] seg7(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [15:0] hex_of(input logic [7:0] b);
      return {seg7(int'(b[7:4])), seg7(int'(b[3:0]))};
   endfunction

   // ---------------- model ----------------
   task automatic model_step(input bit up, input bit dn);
      bit cw = 1'b0, bw = 1'b0, cs = 1'b0, bs = 1'b0;
      if (up && !dn) begin
         cw    = (val_w == 99);
         val_w = cw ? 0 : val_w + 1;
         cs    = (val_s == 99);
         val_s = cs ? 99 : val_s + 1;
      end else if (dn && !up) begin
         bw    = (val_w == 0);
         val_w = bw ? 99 : val_w - 1;
         bs    = (val_s == 0);
         val_s = bs ? 0 : val_s - 1;
      end
      exp_q.push_back({to_bcd(val_w), cw, bw, to_bcd(val_s), cs, bs});
   endtask

   task automatic model_load(input logic [7:0] v);
      int hi = int'(v[7:4]);
      int lo = int'(v[3:0]);
      bit e  = 1'b0;
      if (hi > 9) begin hi = 0; e = 1'b1; end
      if (lo > 9) begin lo = 0; e = 1'b1; end
      val_w = hi * 10 + lo;
      val_s = val_w;
      err   = e;
      exp_q.push_back({to_bcd(val_w), 2'b00, to_bcd(val_s), 2'b00});
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge CLK1);
   endtask

   task automatic set_btn(input logic up_n, input logic dn_n);
      bus_w.BTN_UP_N = up_n;  bus_s.BTN_UP_N = up_n;
      bus_w.BTN_DN_N = dn_n;  bus_s.BTN_DN_N = dn_n;
   endtask

   task automatic set_load(input logic ld, input logic [7:0] v);
      bus_w.LOAD = ld;  bus_s.LOAD = ld;
      bus_w.LOAD_VAL = v;  bus_s.LOAD_VAL = v;
   endtask

   task automatic sb_compare(input string tag);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_bcd_w"},    bus_w.BCD,    e[19:12]);
         check({tag, "_hex_w"},    bus_w.HEX,    hex_of(e[19:12]));
         check({tag, "_carry_w"},  bus_w.CARRY,  e[11]);
         check({tag, "_borrow_w"}, bus_w.BORROW, e[10]);
         check({tag, "_bcd_s"},    bus_s.BCD,    e[9:2]);
         check({tag, "_hex_s"},    bus_s.HEX,    hex_of(e[9:2]));
         check({tag, "_carry_s"},  bus_s.CARRY,  e[1]);
         check({tag, "_borrow_s"}, bus_s.BORROW, e[0]);
      end
   endtask

   task automatic check_steady(input string tag);
      check({tag, "_bcd_w"},  bus_w.BCD, to_bcd(val_w));
      check({tag, "_hex_w"},  bus_w.HEX, hex_of(to_bcd(val_w)));
      check({tag, "_bcd_s"},  bus_s.BCD, to_bcd(val_s));
      check({tag, "_hex_s"},  bus_s.HEX, hex_of(to_bcd(val_s)));
      check({tag, "_pulse_w"}, {bus_w.CARRY, bus_w.BORROW}, 2'b00);
      check({tag, "_pulse_s"}, {bus_s.CARRY, bus_s.BORROW}, 2'b00);
      check({tag, "_lerr_w"}, bus_w.LOAD_ERR, err);
      check({tag, "_lerr_s"}, bus_s.LOAD_ERR, err);
   endtask

   // Press one or both buttons at a negedge; the count must hold through edge
   // DBC+2 and change on edge DBC+3, with pulses lasting exactly one cycle.
   task automatic do_press(input string tag, input bit up, input bit dn, input int hold);
      logic [7:0] pw = to_bcd(val_w);
      logic [7:0] ps = to_bcd(val_s);
      set_btn(~up, ~dn);
      model_step(up, dn);
      tick(DBC + 2);
      check({tag, "_early_w"}, bus_w.BCD, pw);
      check({tag, "_early_s"}, bus_s.BCD, ps);
      tick(1);
      sb_compare(tag);
      tick(1);
      check({tag, "_pend_w"}, {bus_w.CARRY, bus_w.BORROW}, 2'b00);
      check({tag, "_pend_s"}, {bus_s.CARRY, bus_s.BORROW}, 2'b00);
      tick(hold - (DBC + 4));
      set_btn(1'b1, 1'b1);
      tick(40);
      check_steady({tag, "_rel"});
   endtask

   task automatic do_load(input string tag, input logic [7:0] v);
      set_load(1'b1, v);
      model_load(v);
      tick(1);
      set_load(1'b0, 8'h00);
      sb_compare(tag);
      check({tag, "_lerr_w"}, bus_w.LOAD_ERR, err);
      check({tag, "_lerr_s"}, bus_s.LOAD_ERR, err);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "simulation time limit");
   end

   // ---------------- main sequence ----------------
   initial begin
      RST_N = 1'b0;
      set_btn(1'b1, 1'b1);
      set_load(1'b0, 8'h00);

      // Reset state
      tick(10);
      check_steady("reset");
      check("reset_hex_w", bus_w.HEX, 16'hC0C0);
      RST_N = 1'b1;
      tick(2);
      check_steady("post_reset");

      // Count up 01..09, then 10
      for (int i = 1; i <= 10; i++) begin
         do_press($sformatf("up%0d", i), 1'b1, 1'b0, 32);
      end
      check("count10_w", bus_w.BCD, 8'h10);

      // Glitch rejection
      set_btn(1'b0, 1'b1);
      tick(10);
      set_btn(1'b1, 1'b1);
      tick(40);
      check_steady("glitch");

      // Long hold: exactly one increment
      do_press("hold200", 1'b1, 1'b0, 200);
      check("hold200_w", bus_w.BCD, 8'h11);

      // Wrap / saturate at the top
      do_load("load99", 8'h99);
      do_press("up_top", 1'b1, 1'b0, 32);

      // Wrap / saturate at the bottom
      do_load("load00", 8'h00);
      do_press("dn_bot", 1'b0, 1'b1, 32);

      // A few random down steps from a random legal value
      do_load("load_rand", to_bcd($urandom_range(20, 99)));
      for (int i = 0; i < 3; i++) begin
         do_press($sformatf("dn_rand%0d", i), 1'b0, 1'b1, $urandom_range(30, 45));
      end

      // Invalid digit loads as 0 and sets the sticky error; a valid load clears it
      do_load("load3A", 8'h3A);
      check("load3A_bcd", bus_w.BCD, 8'h30);
      tick(3);
      check_steady("err_sticky");
      do_load("load42", 8'h42);

      // LOAD on the same edge as a step: load wins, no pulse
      set_btn(1'b0, 1'b1);
      tick(DBC + 2);
      check("coinc_early_w", bus_w.BCD, 8'h42);
      set_load(1'b1, 8'h57);
      model_load(8'h57);
      tick(1);
      set_load(1'b0, 8'h00);
      sb_compare("coinc");
      tick(20);
      set_btn(1'b1, 1'b1);
      tick(40);
      check_steady("coinc_rel");

      // Up and down together: no change, no pulse
      do_press("both", 1'b1, 1'b1, 32);

      // Reset while a button is held
      set_btn(1'b0, 1'b1);
      model_step(1'b1, 1'b0);
      tick(DBC + 3);
      sb_compare("pre_rst");
      tick(5);
      RST_N = 1'b0;
      val_w = 0;
      val_s = 0;
      err   = 1'b0;
      tick(10);
      check_steady("mid_rst");
      RST_N = 1'b1;
      model_step(1'b1, 1'b0);
      tick(DBC + 2);
      check("rst_early_w", bus_w.BCD, 8'h00);
      tick(1);
      sb_compare("rst_step");
      tick(60);
      check_steady("rst_held");
      check("rst_db_w", bus_w.DB_UP_N, 1'b0);
      set_btn(1'b1, 1'b1);
      tick(40);
      check_steady("rst_rel");
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
